// File: rtl/bin_to_bcd_if.sv
// Request/result bundle between a producer of binary values and bin_to_bcd_seq.
// The master drives start/bin; the converter (slave) returns status and the BCD result.
interface bin_to_bcd_if #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Values above the decimal range of DIGITS saturate to all nines and raise overflow.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    bin_to_bcd_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic longint unsigned max_decimal();
        longint unsigned r;
        r = 1;
        for (int k = 0; k < DIGITS; k++) r = r * 10;
        return r - 1;
    endfunction

    localparam longint unsigned MAX_DEC = max_decimal();

    // Per-digit correction before each shift; digits never carry into each other.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int k = 0; k < DIGITS; k++) begin
            if (s[4*k +: 4] >= 4'd5) r[4*k +: 4] = s[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] s, input logic sat);
        logic [BCD_W-1:0] r;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = sat ? 4'd9 : s[4*k +: 4];
        end
        return r;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCD_W-1:0] scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_flag_q, ovf_flag_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic             accept;

    // A new request is taken in IDLE and also in DONE, giving gapless back-to-back runs.
    assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_flag_d = ovf_flag_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                {scratch_d, shreg_d} = {add3_digits(scratch_q), shreg_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    bcd_d   = saturate(scratch_d, ovf_flag_q);
                    ovf_d   = ovf_flag_q;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d    = ST_SHIFT;
            shreg_d    = bus.bin;
            scratch_d  = '0;
            cnt_d      = CNT_W'(WIDTH);
            ovf_flag_d = (64'(bus.bin) > MAX_DEC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_flag_q <= ovf_flag_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == ST_SHIFT);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results, a negedge
// monitor pops and compares them on every done pulse.
module tb_bin_to_bcd_seq;
    localparam int WIDTH  = 14;
    localparam int DIGITS = 4;
    localparam int LAT    = WIDTH;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;
    exp_t sb[$];

    bin_to_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, pending=%0d required=0", sb.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        int t;
        t = (v > 9999) ? 9999 : v;
        return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
    endfunction

    function automatic exp_t mk_exp(input int v, input int acc);
        exp_t e;
        e.bcd = ref_bcd(v);
        e.ovf = (v > 9999);
        e.acc = acc;
        return e;
    endfunction

    // Waits (bounded) for the converter to be free, then requests one conversion.
    task automatic issue(input int v);
        int waited;
        waited = 0;
        @(negedge clk);
        while (bus.busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) check("issue_wait_timeout", 1, 0);
        bus.start = 1'b1;
        bus.bin   = 14'(v);
        sb.push_back(mk_exp(v, cyc + 1));
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else if (bus.busy) begin
            busy_run++;
        end else begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done pulse with bcd=0x%0h, none required", bus.bcd);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", cyc - e.acc, LAT);
                    check("busy_len", busy_run, LAT);
                    check("bcd", int'(bus.bcd), int'(e.bcd));
                    check("overflow", int'(bus.overflow), int'(e.ovf));
                    for (int k = 0; k < DIGITS; k++)
                        check("digit_le9", int'(bus.bcd[4*k +: 4] <= 4'd9), 1);
                end
            end
            busy_run = 0;
        end
    end

    initial begin
        int waited;
        bus.start = 1'b0;
        bus.bin   = '0;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_bcd", int'(bus.bcd), 0);
        check("rst_ovf", int'(bus.overflow), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue(0);
        issue(1234);
        issue(9999);
        issue(10000);
        issue(7);

        // Held start: bin changes mid-conversion must be ignored, then taken in DONE.
        @(negedge clk);
        while (bus.busy) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 14'd1234;
        sb.push_back(mk_exp(1234, cyc + 1));
        @(negedge clk);
        bus.bin = 14'd42;
        waited = 0;
        while (!bus.done && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) check("held_done_timeout", 1, 0);
        sb.push_back(mk_exp(42, cyc + 1));
        @(posedge clk);
        #1 bus.start = 1'b0;

        // Asynchronous reset mid-conversion.
        issue(5555);
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_bcd", int'(bus.bcd), 0);
        check("abort_ovf", int'(bus.overflow), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(808);

        // Sparse sweep plus the full neighbourhood of the saturation boundary.
        for (int v = 0; v < 16384; v += 37) issue(v);
        for (int v = 9990; v <= 10010; v++) issue(v);
        issue(16383);

        waited = 0;
        while ((sb.size() != 0 || bus.busy) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
